i2c_config_sequencer: RTL

Walks a register-write table and drives the I2C write engine once per entry to bring up the camera sensor after reset or on request. It sits between the board-level control logic and the I2C write engine, and owns the engine's `enable`/`END` handshake. It also handles per-entry NACK detection, optional retry, a stall watchdog and completion/error status. The 16'hFFFF delay entries are passed through unchanged; the write engine executes them as delays.

---
 rtl/i2c_config_sequencer.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_config_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_config_sequencer
//
// Brings up the camera sensor after reset or on request. It walks a
// register-write table and starts the I2C write engine once for each entry.
// The block owns the engine's enable/END handshake. It detects a NACK on each
// entry, runs a stall watchdog on both handshake phases, and reports
// completion and error status. Entries of 16'hFFFF are passed through
// unchanged, and the write engine executes them as delays.
//
// Optional feature macro: I2C_CFG_RETRY_EN
//   defined   : a NACKed entry is relaunched up to MAX_RETRY extra times
//   undefined : a NACK fails the entry at once and no retry counter is built
//
// Parameters
//   LUT_SIZE    number of table entries (indices 0..LUT_SIZE-1)
//   IDX_W       width of lut_index
//   SLAVE_ADDR  constant driven on i2c_sl_addr
//   BYTE_NUM    constant driven on i2c_byte_num
//   POR_CYCLES  wait after reset before the first entry
//   TIMEOUT     watchdog limit, in cycles, for each handshake phase
//   MAX_RETRY   extra attempts for a NACKed entry (retry build only)
//
// Ports
//   clk           single clock, shared with the write engine
//   reset         synchronous, active-high
//   start         one-cycle pulse; re-runs the table, honoured in DONE/IDLE
//   lut_index     table address
//   lut_data      combinational table read of lut_index
//   i2c_enable    engine enable (low starts a transfer)
//   i2c_reg_data  registered copy of lut_data, taken in LOAD
//   i2c_sl_addr   engine slave address
//   i2c_byte_num  engine byte count
//   i2c_end       engine END: 1 = idle, 0 = transfer running
//   i2c_ack       engine ACK: 1 = NACK seen during the transfer
//   busy          table run in progress
//   done          table completed; held until the next run or reset
//   error         sticky: at least one entry failed or timed out
//   err_cnt       number of failed entries, saturating at 255
//
// state     | meaning
// ----------+--------------------------------------------------------------
// POR_WAIT  | power-on wait of POR_CYCLES before the first entry
// LOAD      | latch lut_data into i2c_reg_data
// LAUNCH    | drop i2c_enable to start the engine
// WAIT_BUSY | hold enable low until the engine reports END=0
// WAIT_DONE | enable back high; wait for END=1
// CHECK     | sample the ACK (NACK) flag of the finished transfer
// NEXT      | advance the table index, or finish the run
// DONE      | run complete; wait for start
// IDLE      | reserved; like DONE with done=0
// -----------------------------------------------------------------------------
module i2c_config_sequencer #(
   parameter int          LUT_SIZE   = 64,
   parameter int          IDX_W      = 8,
   parameter logic [7:0]  SLAVE_ADDR = 8'h42,
   parameter logic [7:0]  BYTE_NUM   = 8'd2,
   parameter logic [15:0] POR_CYCLES = 16'd2000,
   parameter logic [15:0] TIMEOUT    = 16'd4000,
   parameter int          MAX_RETRY  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [IDX_W-1:0] lut_index,
   input  logic [15:0]      lut_data,
   output logic             i2c_enable,
   output logic [15:0]      i2c_reg_data,
   output logic [7:0]       i2c_sl_addr,
   output logic [7:0]       i2c_byte_num,
   input  logic             i2c_end,
   input  logic             i2c_ack,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [7:0]       err_cnt
);

   typedef enum logic [3:0] {
      ST_POR_WAIT  = 4'd0,
      ST_LOAD      = 4'd1,
      ST_LAUNCH    = 4'd2,
      ST_WAIT_BUSY = 4'd3,
      ST_WAIT_DONE = 4'd4,
      ST_CHECK     = 4'd5,
      ST_NEXT      = 4'd6,
      ST_DONE      = 4'd7,
      ST_IDLE      = 4'd8
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);

   // The POR timer counts down to zero. Loading POR_CYCLES-1 keeps the FSM in
   // POR_WAIT for exactly POR_CYCLES cycles after reset is released.
   localparam logic [15:0] POR_LOAD = (POR_CYCLES == 16'd0) ? 16'd0 : POR_CYCLES - 16'd1;
   localparam logic [15:0] WDOG_LAST = TIMEOUT - 16'd1;

`ifdef I2C_CFG_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] lut_index_q, lut_index_d;
   logic [15:0]      reg_data_q, reg_data_d;
   logic             enable_q, enable_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [15:0]      por_cnt_q, por_cnt_d;
   logic [15:0]      wdog_cnt_q, wdog_cnt_d;
   logic             wdog_hit;
   logic             entry_fail;
`ifdef I2C_CFG_RETRY_EN
   logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

   // The watchdog counts cycles spent in one wait state. It fires on the
   // TIMEOUT-th cycle of that state.
   assign wdog_hit = (wdog_cnt_q == WDOG_LAST);

   always_comb begin
      state_d     = state_q;
      lut_index_d = lut_index_q;
      reg_data_d  = reg_data_q;
      enable_d    = enable_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_cnt_d   = err_cnt_q;
      por_cnt_d   = por_cnt_q;
      // The watchdog clears on every cycle outside the wait states and on
      // every state change, so it only has to advance while the FSM stays put.
      wdog_cnt_d  = '0;
      entry_fail  = 1'b0;
`ifdef I2C_CFG_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif

      case (state_q)
         ST_POR_WAIT: begin
            if (por_cnt_q == 16'd0) begin
               state_d = ST_LOAD;
            end else begin
               por_cnt_d = por_cnt_q - 16'd1;
            end
         end

         ST_LOAD: begin
            reg_data_d = lut_data;
            state_d    = ST_LAUNCH;
         end

         ST_LAUNCH: begin
            enable_d = 1'b0;
            state_d  = ST_WAIT_BUSY;
         end

         ST_WAIT_BUSY: begin
            if (!i2c_end) begin
               enable_d = 1'b1;
               state_d  = ST_WAIT_DONE;
            end else if (wdog_hit) begin
               entry_fail = 1'b1;
               enable_d   = 1'b1;
               state_d    = ST_NEXT;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 16'd1;
            end
         end

         ST_WAIT_DONE: begin
            // Enable stays high here so the engine parks at the end of the
            // transfer instead of starting a new one.
            if (i2c_end) begin
               state_d = ST_CHECK;
            end else if (wdog_hit) begin
               entry_fail = 1'b1;
               enable_d   = 1'b1;
               state_d    = ST_NEXT;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 16'd1;
            end
         end

         ST_CHECK: begin
            if (i2c_ack) begin
`ifdef I2C_CFG_RETRY_EN
               if (retry_cnt_q < RETRY_LIMIT) begin
                  // Relaunch the same entry: the index stays and LOAD
                  // re-reads the same table word.
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                  state_d     = ST_LOAD;
               end else begin
                  entry_fail = 1'b1;
                  state_d    = ST_NEXT;
               end
`else
               entry_fail = 1'b1;
               state_d    = ST_NEXT;
`endif
            end else begin
               state_d = ST_NEXT;
            end
         end

         ST_NEXT: begin
            if (lut_index_q == LAST_IDX) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               lut_index_d = lut_index_q + IDX_W'(1);
`ifdef I2C_CFG_RETRY_EN
               retry_cnt_d = '0;
`endif
               state_d     = ST_LOAD;
            end
         end

         ST_DONE, ST_IDLE: begin
            if (start) begin
               lut_index_d = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_cnt_d   = '0;
`ifdef I2C_CFG_RETRY_EN
               retry_cnt_d = '0;
`endif
               state_d     = ST_LOAD;
            end
         end

         default: begin
            // Unused encodings park in the reserved idle state, where a
            // start pulse can recover a clean run.
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (entry_fail) begin
         error_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_POR_WAIT;
         lut_index_q <= '0;
         reg_data_q  <= '0;
         enable_q    <= 1'b1;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         por_cnt_q   <= POR_LOAD;
         wdog_cnt_q  <= '0;
`ifdef I2C_CFG_RETRY_EN
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lut_index_q <= lut_index_d;
         reg_data_q  <= reg_data_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_cnt_q   <= err_cnt_d;
         por_cnt_q   <= por_cnt_d;
         wdog_cnt_q  <= wdog_cnt_d;
`ifdef I2C_CFG_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   assign lut_index    = lut_index_q;
   assign i2c_enable   = enable_q;
   assign i2c_reg_data = reg_data_q;
   assign i2c_sl_addr  = SLAVE_ADDR;
   assign i2c_byte_num = BYTE_NUM;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_cnt      = err_cnt_q;

endmodule
